wm8731_adc_rx: RTL and testbench



---
 rtl/wm8731_adc_rx.sv | 128 ++++++++++++
 tb/tb_wm8731_adc_rx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wm8731_adc_rx.sv
// WM8731 ADC capture: right-justified serial stream (codec master) to parallel stereo pairs in the clk50M domain.
// Optional mono mix output is enabled by defining WM8731_ADC_RX_MONO_EN.
module wm8731_adc_rx #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk50M,
  input  logic              rst,
  input  logic              BCLK,
  input  logic              ADCLRC,
  input  logic              ADCDAT,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              sample_valid,
  output logic              frame_err,
  output logic [DATA_W-1:0] mono_data
);

  typedef enum logic [1:0] {ARM, WAIT_L, WAIT_R} state_t;

  localparam logic [5:0] FULL_CNT = 6'(DATA_W);
  localparam logic [5:0] SAT_CNT  = 6'd63;

  logic [SYNC_STAGES-1:0] bclk_sync, lrc_sync, dat_sync;
  logic                   bclk_d;
  logic                   bclk_s, lrc_now, dat_now;
  logic                   bclk_rise, boundary, short_word;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] left_hold;
  logic [5:0]        bit_cnt;
  logic              lrc_prev;

  // BCLK, ADCLRC and ADCDAT travel through equal-depth chains, so the sampled
  // LRC/DAT stay aligned with the detected BCLK edge.
  always_ff @(posedge clk50M) begin
    if (rst) begin
      bclk_sync <= '0;
      lrc_sync  <= '0;
      dat_sync  <= '0;
      bclk_d    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling its pre-edge input, which is what makes a shift chain a chain.
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], BCLK};
      lrc_sync  <= {lrc_sync[SYNC_STAGES-2:0],  ADCLRC};
      dat_sync  <= {dat_sync[SYNC_STAGES-2:0],  ADCDAT};
      bclk_d    <= bclk_s;
    end
  end

  assign bclk_s     = bclk_sync[SYNC_STAGES-1];
  assign lrc_now    = lrc_sync[SYNC_STAGES-1];
  assign dat_now    = dat_sync[SYNC_STAGES-1];
  assign bclk_rise  = bclk_s & ~bclk_d;
  assign boundary   = bclk_rise & (lrc_now != lrc_prev);
  assign short_word = (bit_cnt < FULL_CNT);

`ifdef WM8731_ADC_RX_MONO_EN
  logic [DATA_W:0] mono_sum;
  assign mono_sum = {left_hold[DATA_W-1], left_hold} + {shreg[DATA_W-1], shreg};
`else
  assign mono_data = '0;
`endif

  always_ff @(posedge clk50M) begin
    if (rst) begin
      state        <= ARM;
      shreg        <= '0;
      left_hold    <= '0;
      bit_cnt      <= '0;
      lrc_prev     <= 1'b0;
      left_data    <= '0;
      right_data   <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
`ifdef WM8731_ADC_RX_MONO_EN
      mono_data    <= '0;
`endif
    end else begin
      // NOTE: pulse outputs default low every cycle so a single branch below can raise them for exactly one clock.
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;

      if (bclk_rise) begin
        shreg    <= {shreg[DATA_W-2:0], dat_now};
        lrc_prev <= lrc_now;
        if (boundary)
          bit_cnt <= 6'd1;
        else if (bit_cnt != SAT_CNT)
          bit_cnt <= bit_cnt + 6'd1;
      end

      // On a boundary, shreg still holds the finished word (dat_now belongs to the new half-frame).
      if (boundary) begin
        unique case (state)
          ARM: state <= WAIT_L;
          WAIT_L: begin
            if (short_word) begin
              frame_err <= 1'b1;
            end else if (lrc_prev) begin
              left_hold <= shreg;
              state     <= WAIT_R;
            end
          end
          WAIT_R: begin
            if (short_word) begin
              frame_err <= 1'b1;
              state     <= WAIT_L;
            end else if (!lrc_prev) begin
              left_data    <= left_hold;
              right_data   <= shreg;
              sample_valid <= 1'b1;
`ifdef WM8731_ADC_RX_MONO_EN
              mono_data    <= mono_sum[DATA_W:1];
`endif
              state        <= WAIT_L;
            end else begin
              left_hold <= shreg;
            end
          end
          default: state <= ARM;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wm8731_adc_rx.sv
// Directed bench for wm8731_adc_rx: bit-banged codec stream, per-scenario tasks with inline checks.
// Mono expectations follow WM8731_ADC_RX_MONO_EN.
module tb_wm8731_adc_rx;

  localparam int DW   = 16;
  localparam int SYNC = 2;

`ifdef WM8731_ADC_RX_MONO_EN
  localparam logic [DW-1:0] M_BASIC = 16'hDF00;
  localparam logic [DW-1:0] M_EXT   = 16'hFFFF;
  localparam logic [DW-1:0] M_RSTRT = 16'h2AAA;
`else
  localparam logic [DW-1:0] M_BASIC = 16'h0000;
  localparam logic [DW-1:0] M_EXT   = 16'h0000;
  localparam logic [DW-1:0] M_RSTRT = 16'h0000;
`endif

  logic          clk50M = 1'b0;
  logic          rst    = 1'b1;
  logic          BCLK   = 1'b0;
  logic          ADCLRC = 1'b0;
  logic          ADCDAT = 1'b0;
  logic [DW-1:0] left_data, right_data, mono_data;
  logic          sample_valid, frame_err;

  wm8731_adc_rx #(.DATA_W(DW), .SYNC_STAGES(SYNC)) dut (
    .clk50M      (clk50M),
    .rst         (rst),
    .BCLK        (BCLK),
    .ADCLRC      (ADCLRC),
    .ADCDAT      (ADCDAT),
    .left_data   (left_data),
    .right_data  (right_data),
    .sample_valid(sample_valid),
    .frame_err   (frame_err),
    .mono_data   (mono_data)
  );

  always #10 clk50M = ~clk50M;

  int total = 0;
  int bad   = 0;

  longint        cyc = 0;
  longint        last_rise_cyc = 0;
  logic          rst_q = 1'b1;
  logic [DW-1:0] v_left[$], v_right[$], v_mono[$];
  longint        v_cyc[$];
  int            ferr_cnt = 0, both_cnt = 0, spur_cnt = 0;
  logic [DW-1:0] prev_l = '0, prev_r = '0;
  logic [DW-1:0] snap_l, snap_r, snap_m;
  logic [1:0]    snap_p;

  always @(posedge clk50M) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  // Event recorder: valid pairs, error pulses, overlap and output changes outside a valid.
  always @(negedge clk50M) begin
    if (!rst_q) begin
      if (sample_valid) begin
        v_left.push_back(left_data);
        v_right.push_back(right_data);
        v_mono.push_back(mono_data);
        v_cyc.push_back(cyc);
      end
      if (frame_err) ferr_cnt++;
      if (sample_valid && frame_err) both_cnt++;
      if (!sample_valid && (left_data !== prev_l || right_data !== prev_r)) spur_cnt++;
    end
    prev_l = left_data;
    prev_r = right_data;
  end

  task automatic do_reset();
    rst = 1'b1; BCLK = 1'b0; ADCLRC = 1'b0; ADCDAT = 1'b0;
    repeat (3) @(negedge clk50M);
    rst = 1'b0;
    v_left.delete(); v_right.delete(); v_mono.delete(); v_cyc.delete();
    ferr_cnt = 0; both_cnt = 0; spur_cnt = 0;
    @(negedge clk50M);
  endtask

  // One half-frame of nbits BCLK periods (16 clk each), word right-justified with zero padding.
  // rst_bit >= 0 pulses rst for 3 cycles in that bit's low phase and snapshots the outputs.
  task automatic send_half(input logic lrc, input logic [DW-1:0] w, input int nbits, input int rst_bit);
    for (int i = 0; i < nbits; i++) begin
      int p;
      p = nbits - 1 - i;
      BCLK = 1'b0; ADCLRC = lrc;
      ADCDAT = (p < DW) ? w[p] : 1'b0;
      if (i == rst_bit) begin
        rst = 1'b1;
        repeat (3) @(negedge clk50M);
        rst = 1'b0;
        snap_l = left_data; snap_r = right_data; snap_m = mono_data;
        snap_p = {sample_valid, frame_err};
        repeat (5) @(negedge clk50M);
      end else begin
        repeat (8) @(negedge clk50M);
      end
      BCLK = 1'b1;
      if (i == 0) last_rise_cyc = cyc;
      repeat (8) @(negedge clk50M);
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int n);
    send_half(1'b1, l, n, -1);
    send_half(1'b0, r, n, -1);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (left_data  !== '0)   begin bad++; $display("FAIL reset_left: got %h want 0000", left_data); end
    total++; if (right_data !== '0)   begin bad++; $display("FAIL reset_right: got %h want 0000", right_data); end
    total++; if (mono_data  !== '0)   begin bad++; $display("FAIL reset_mono: got %h want 0000", mono_data); end
    total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", sample_valid); end
    total++; if (frame_err  !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
  endtask

  task automatic test_basic();
    longint lat;
    do_reset();
    for (int f = 0; f < 3; f++) send_frame(16'h1234, 16'hABCD, 32);
    send_half(1'b1, 16'h1234, 32, -1);
    repeat (4) @(negedge clk50M);
    total++; if (v_left.size() != 3) begin bad++; $display("FAIL basic_count: got %0d want 3", v_left.size()); end
    for (int k = 0; k < v_left.size(); k++) begin
      total++; if (v_left[k]  !== 16'h1234) begin bad++; $display("FAIL basic_left[%0d]: got %h want 1234", k, v_left[k]); end
      total++; if (v_right[k] !== 16'hABCD) begin bad++; $display("FAIL basic_right[%0d]: got %h want abcd", k, v_right[k]); end
      total++; if (v_mono[k]  !== M_BASIC)  begin bad++; $display("FAIL basic_mono[%0d]: got %h want %h", k, v_mono[k], M_BASIC); end
    end
    for (int k = 1; k < v_cyc.size(); k++) begin
      total++;
      if (v_cyc[k] - v_cyc[k-1] != 1024) begin bad++; $display("FAIL basic_spacing[%0d]: got %0d want 1024", k, v_cyc[k] - v_cyc[k-1]); end
    end
    if (v_cyc.size() == 3) begin
      lat = v_cyc[2] - last_rise_cyc;
      total++;
      if (lat < SYNC + 1 || lat > SYNC + 3) begin bad++; $display("FAIL basic_latency: got %0d want %0d..%0d", lat, SYNC + 1, SYNC + 3); end
    end
    total++; if (ferr_cnt != 0) begin bad++; $display("FAIL basic_ferr: got %0d want 0", ferr_cnt); end
    total++; if (spur_cnt != 0) begin bad++; $display("FAIL basic_hold: got %0d changes want 0", spur_cnt); end
  endtask

  task automatic test_extremes();
    do_reset();
    send_frame(16'h8000, 16'h7FFF, 32);
    send_half(1'b1, 16'h8000, 32, -1);
    repeat (4) @(negedge clk50M);
    total++; if (v_left.size() != 1) begin bad++; $display("FAIL ext_count: got %0d want 1", v_left.size()); end
    if (v_left.size() >= 1) begin
      total++; if (v_left[0]  !== 16'h8000) begin bad++; $display("FAIL ext_left: got %h want 8000", v_left[0]); end
      total++; if (v_right[0] !== 16'h7FFF) begin bad++; $display("FAIL ext_right: got %h want 7fff", v_right[0]); end
      total++; if (v_mono[0]  !== M_EXT)    begin bad++; $display("FAIL ext_mono: got %h want %h", v_mono[0], M_EXT); end
    end
  endtask

  task automatic test_short_frame();
    do_reset();
    send_frame(16'h1234, 16'hABCD, 32);
    send_half(1'b1, 16'h1234, 32, -1);
    send_half(1'b0, 16'hABCD, 10, -1);
    send_frame(16'h5A5A, 16'hA5A5, 32);
    send_half(1'b1, 16'h5A5A, 32, -1);
    repeat (4) @(negedge clk50M);
    total++; if (v_left.size() != 2) begin bad++; $display("FAIL short_count: got %0d want 2", v_left.size()); end
    total++; if (ferr_cnt != 1)      begin bad++; $display("FAIL short_ferr: got %0d want 1", ferr_cnt); end
    total++; if (both_cnt != 0)      begin bad++; $display("FAIL short_overlap: got %0d want 0", both_cnt); end
    if (v_left.size() == 2) begin
      total++; if (v_left[0]  !== 16'h1234) begin bad++; $display("FAIL short_left0: got %h want 1234", v_left[0]); end
      total++; if (v_right[0] !== 16'hABCD) begin bad++; $display("FAIL short_right0: got %h want abcd", v_right[0]); end
      total++; if (v_left[1]  !== 16'h5A5A) begin bad++; $display("FAIL short_left1: got %h want 5a5a", v_left[1]); end
      total++; if (v_right[1] !== 16'hA5A5) begin bad++; $display("FAIL short_right1: got %h want a5a5", v_right[1]); end
    end
  endtask

  task automatic test_exact_width();
    do_reset();
    for (int f = 0; f < 2; f++) send_frame(16'h0001, 16'hFFFE, 16);
    send_half(1'b1, 16'h0001, 16, -1);
    repeat (4) @(negedge clk50M);
    total++; if (v_left.size() != 2) begin bad++; $display("FAIL exact_count: got %0d want 2", v_left.size()); end
    total++; if (ferr_cnt != 0)      begin bad++; $display("FAIL exact_ferr: got %0d want 0", ferr_cnt); end
    for (int k = 0; k < v_left.size(); k++) begin
      total++; if (v_left[k]  !== 16'h0001) begin bad++; $display("FAIL exact_left[%0d]: got %h want 0001", k, v_left[k]); end
      total++; if (v_right[k] !== 16'hFFFE) begin bad++; $display("FAIL exact_right[%0d]: got %h want fffe", k, v_right[k]); end
    end
    if (v_cyc.size() == 2) begin
      total++;
      if (v_cyc[1] - v_cyc[0] != 512) begin bad++; $display("FAIL exact_spacing: got %0d want 512", v_cyc[1] - v_cyc[0]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_frame(16'h1234, 16'hABCD, 32);
    send_half(1'b1, 16'h1234, 32, 20);
    send_half(1'b0, 16'hABCD, 32, -1);
    send_frame(16'h0F0F, 16'hF0F0, 32);
    send_half(1'b1, 16'h0F0F, 32, -1);
    repeat (4) @(negedge clk50M);
    total++; if (snap_l !== '0)    begin bad++; $display("FAIL midrst_left: got %h want 0000", snap_l); end
    total++; if (snap_r !== '0)    begin bad++; $display("FAIL midrst_right: got %h want 0000", snap_r); end
    total++; if (snap_m !== '0)    begin bad++; $display("FAIL midrst_mono: got %h want 0000", snap_m); end
    total++; if (snap_p !== 2'b00) begin bad++; $display("FAIL midrst_pulses: got %b want 00", snap_p); end
    total++; if (v_left.size() != 2) begin bad++; $display("FAIL midrst_count: got %0d want 2", v_left.size()); end
    if (v_left.size() == 2) begin
      total++; if (v_left[0]  !== 16'h1234) begin bad++; $display("FAIL midrst_left0: got %h want 1234", v_left[0]); end
      total++; if (v_left[1]  !== 16'h0F0F) begin bad++; $display("FAIL midrst_left1: got %h want 0f0f", v_left[1]); end
      total++; if (v_right[1] !== 16'hF0F0) begin bad++; $display("FAIL midrst_right1: got %h want f0f0", v_right[1]); end
    end
  endtask

  task automatic test_right_start();
    do_reset();
    send_half(1'b0, 16'h1111, 32, -1);
    send_frame(16'h2222, 16'h3333, 32);
    send_half(1'b1, 16'h2222, 32, -1);
    repeat (4) @(negedge clk50M);
    total++; if (v_left.size() != 1) begin bad++; $display("FAIL rstart_count: got %0d want 1", v_left.size()); end
    total++; if (ferr_cnt != 0)      begin bad++; $display("FAIL rstart_ferr: got %0d want 0", ferr_cnt); end
    if (v_left.size() >= 1) begin
      total++; if (v_left[0]  !== 16'h2222) begin bad++; $display("FAIL rstart_left: got %h want 2222", v_left[0]); end
      total++; if (v_right[0] !== 16'h3333) begin bad++; $display("FAIL rstart_right: got %h want 3333", v_right[0]); end
      total++; if (v_mono[0]  !== M_RSTRT)  begin bad++; $display("FAIL rstart_mono: got %h want %h", v_mono[0], M_RSTRT); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_short_frame();
    test_exact_width();
    test_reset_mid();
    test_right_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
